receptor_multibyte: RTL and testbench
=====================================

RECEPTOR_MULTIBYTE -- requirements
Module: receptor_multibyte

Interface
REQ-001 Parameter N_BYTES, default 2, bytes per frame (legal 1..8).
REQ-002 Parameter BYTE_W, default 8, bits per byte.
REQ-003 Parameter MSB_FIRST, default 1: 1 means the first byte received lands in the top slice of data_out; 0 means the first byte lands in bits [BYTE_W-1:0].
REQ-004 Parameter TIMEOUT_CYCLES, default 50_000, maximum idle clocks allowed between bytes of one frame.
REQ-005 clock  in  1  system clock; all state changes on its rising edge.
REQ-006 reset  in  1  asynchronous, active-low; asserting 0 clears all state immediately.
REQ-007 byte_valid  in  1  one-cycle pulse per received byte from the upstream serial receiver.
REQ-008 byte_data  in  BYTE_W  received byte; sampled only when byte_valid=1.
REQ-009 byte_parity_ok  in  1  parity status of byte_data; sampled with byte_valid.
REQ-010 frame_ack  in  1  consumer accepts the held frame.
REQ-011 data_out  out  N_BYTES*BYTE_W  last completed frame.
REQ-012 frame_valid  out  1  high while a completed frame is held.
REQ-013 frame_parity_ok  out  1  AND of byte_parity_ok over all bytes of the held frame.
REQ-014 overrun  out  1  one-cycle pulse when a byte is dropped.
REQ-015 timeout  out  1  one-cycle pulse when a partial frame is discarded.
REQ-016 byte_count  out  clog2(N_BYTES+1)  bytes stored in the current partial frame.
REQ-017 db_estado  out  2  FSM state code: IDLE=00, RECV=01, FULL=10.

Function
REQ-018 Bytes are assembled in an internal shadow register; data_out and frame_parity_ok update only on frame completion and are otherwise held stable.
REQ-019 IDLE + byte_valid: store the byte in slot 0, set byte_count=1, load the parity accumulator with byte_parity_ok, and go to RECV (to FULL if N_BYTES=1).
REQ-020 RECV + byte_valid: store the byte in slot byte_count, increment byte_count, and AND byte_parity_ok into the accumulator.
REQ-021 In RECV, once the last byte is stored: the next cycle is FULL, with frame_valid=1, data_out updated, and byte_count=0.
REQ-022 Latency from the final byte_valid to frame_valid=1 is exactly 1 clock.
REQ-023 FULL: frame_valid is held until frame_ack=1; ack moves the FSM to IDLE and frame_valid drops on the next edge.
REQ-024 FULL + byte_valid + no frame_ack: the byte is dropped, overrun pulses 1 cycle, and the held frame is unchanged.
REQ-025 FULL + byte_valid + frame_ack on the same cycle: the frame is released and the byte is stored as slot 0 of the next frame; next state is RECV (FULL if N_BYTES=1); no overrun.
REQ-026 frame_ack in IDLE or RECV is ignored.
REQ-027 Slot k (k = order of arrival, 0 first) maps to data_out[(N_BYTES-1-k)*BYTE_W +: BYTE_W] when MSB_FIRST=1, and to [k*BYTE_W +: BYTE_W] when MSB_FIRST=0.
REQ-028 byte_count never exceeds N_BYTES and wraps to 0 on completion or discard.

Reset
REQ-029 When reset=0: state=IDLE, data_out=0, frame_valid=0, frame_parity_ok=0, overrun=0, timeout=0, byte_count=0, timeout counter=0, shadow register=0.
REQ-030 Reset asserted mid-frame or while FULL discards everything, with no pulse on timeout or overrun.
REQ-031 After reset is released, the first byte_valid is treated as slot 0.

Configuration
REQ-032 Macro RECEPTOR_MULTIBYTE_TIMEOUT_EN defined: in RECV a counter increments on every clock without byte_valid and clears on byte_valid.
REQ-033 With the macro defined, when the counter reaches TIMEOUT_CYCLES the partial frame is discarded, timeout pulses 1 cycle, byte_count=0, and the state goes to IDLE; held data_out is untouched.
REQ-034 With the macro defined, byte_valid on the same cycle the counter reaches TIMEOUT_CYCLES counts as a valid byte, and no timeout occurs.
REQ-035 Macro undefined: no counter is synthesised, timeout is tied to 0, and RECV waits indefinitely.

Verification
REQ-036 N_BYTES=2, MSB_FIRST=1, bytes 0xA5 then 0x3C, both parity ok -> data_out=0xA53C, frame_valid=1 one clock after the 2nd byte, frame_parity_ok=1.
REQ-037 MSB_FIRST=0, same bytes, second byte parity_ok=0 -> data_out=0x3CA5, frame_parity_ok=0.
REQ-038 Frame held, no ack, byte 0x11 -> overrun pulse, data_out stays 0xA53C; then ack with byte 0x22 on the same cycle -> state RECV, byte_count=1, no overrun.
REQ-039 TIMEOUT_EN set, TIMEOUT_CYCLES=100, one byte then 100 idle clocks -> timeout pulse, IDLE, byte_count=0; with the byte at idle clock 100 instead -> no timeout.
REQ-040 reset=0 asserted asynchronously after 1 of 2 bytes -> all outputs 0 immediately; the next 2 bytes 0x01,0x02 -> data_out=0x0102.

Source files
------------

// File: rtl/receptor_multibyte_if.sv
// Byte-in / frame-out bus for receptor_multibyte.
// master: the side that supplies bytes and acknowledges frames.
// slave:  the frame assembler itself.
interface receptor_multibyte_if #(
    parameter int N_BYTES = 2,
    parameter int BYTE_W  = 8
);
    logic                           byte_valid;
    logic [BYTE_W-1:0]              byte_data;
    logic                           byte_parity_ok;
    logic                           frame_ack;
    logic [N_BYTES*BYTE_W-1:0]      data_out;
    logic                           frame_valid;
    logic                           frame_parity_ok;
    logic                           overrun;
    logic                           timeout;
    logic [$clog2(N_BYTES+1)-1:0]   byte_count;
    logic [1:0]                     db_estado;

    modport master (
        output byte_valid, byte_data, byte_parity_ok, frame_ack,
        input  data_out, frame_valid, frame_parity_ok, overrun, timeout,
               byte_count, db_estado
    );

    modport slave (
        input  byte_valid, byte_data, byte_parity_ok, frame_ack,
        output data_out, frame_valid, frame_parity_ok, overrun, timeout,
               byte_count, db_estado
    );
endinterface

// File: rtl/receptor_multibyte.sv
// receptor_multibyte: gathers N_BYTES bytes from a serial receiver into one
// frame, holds it until the consumer acknowledges, flags dropped bytes.
// Bytes build up in a shadow register; data_out and frame_parity_ok only
// change when a frame completes.
// Optional feature: define RECEPTOR_MULTIBYTE_TIMEOUT_EN to discard a partial
// frame after TIMEOUT_CYCLES idle clocks between bytes.
module receptor_multibyte #(
    parameter int N_BYTES        = 2,
    parameter int BYTE_W         = 8,
    parameter int MSB_FIRST      = 1,
    parameter int TIMEOUT_CYCLES = 50_000
) (
    input logic                  clock,
    input logic                  reset,
    receptor_multibyte_if.slave  bus
);
    localparam int FRAME_W = N_BYTES * BYTE_W;
    localparam int CNT_W   = $clog2(N_BYTES + 1);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RECV = 2'b01,
        FULL = 2'b10
    } state_t;

    state_t             state;
    logic [FRAME_W-1:0] shadow;
    logic [FRAME_W-1:0] shadow_next;
    logic [FRAME_W-1:0] data_out;
    logic               parity_acc;
    logic               parity_next;
    logic               frame_valid;
    logic               frame_parity_ok;
    logic               overrun;
    logic               timeout;
    logic [CNT_W-1:0]   byte_count;
    logic [CNT_W-1:0]   slot;
    logic               take;
    logic               last;
    logic               expire;

    // Bit offset of arrival slot k inside the frame word.
    function automatic int slot_lsb(input logic [CNT_W-1:0] k);
        if (MSB_FIRST != 0)
            return (N_BYTES - 1 - int'(k)) * BYTE_W;
        else
            return int'(k) * BYTE_W;
    endfunction

    // Decide whether the incoming byte is accepted and what the shadow
    // register and parity accumulator become if it is.
    always_comb begin
        take        = bus.byte_valid && ((state != FULL) || bus.frame_ack);
        slot        = (state == RECV) ? byte_count : '0;
        shadow_next = (slot == '0) ? '0 : shadow;
        shadow_next[slot_lsb(slot) +: BYTE_W] = bus.byte_data;
        parity_next = (slot == '0) ? bus.byte_parity_ok
                                   : (parity_acc & bus.byte_parity_ok);
        last        = (int'(slot) == N_BYTES - 1);
    end

`ifdef RECEPTOR_MULTIBYTE_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [TMO_W-1:0] idle_cnt;

    // The idle clock that would bring the count to TIMEOUT_CYCLES discards
    // the frame; a byte arriving on that same clock still wins.
    assign expire = (state == RECV) && !bus.byte_valid &&
                    (idle_cnt == TMO_W'(TIMEOUT_CYCLES - 1));

    // Count idle clocks between bytes while a frame is partially received.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset)
            idle_cnt <= '0;
        else if ((state == RECV) && !bus.byte_valid && !expire)
            idle_cnt <= idle_cnt + 1'b1;
        else
            idle_cnt <= '0;
    end
`else
    assign expire = 1'b0;
`endif

    // Frame assembly FSM with registered outputs.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state           <= IDLE;
            shadow          <= '0;
            data_out        <= '0;
            parity_acc      <= 1'b0;
            frame_valid     <= 1'b0;
            frame_parity_ok <= 1'b0;
            overrun         <= 1'b0;
            timeout         <= 1'b0;
            byte_count      <= '0;
        end else begin
            overrun <= 1'b0;
            timeout <= 1'b0;

            case (state)
                FULL: begin
                    if (bus.frame_ack) begin
                        frame_valid <= 1'b0;
                        state       <= IDLE;
                    end else if (bus.byte_valid) begin
                        // Held frame has priority; the new byte is lost.
                        overrun <= 1'b1;
                    end
                end
                RECV: begin
                    if (expire) begin
                        // Partial frame dropped; the held frame is untouched.
                        timeout    <= 1'b1;
                        byte_count <= '0;
                        shadow     <= '0;
                        state      <= IDLE;
                    end
                end
                default: ;
            endcase

            if (take) begin
                shadow     <= shadow_next;
                parity_acc <= parity_next;
                if (last) begin
                    data_out        <= shadow_next;
                    frame_parity_ok <= parity_next;
                    frame_valid     <= 1'b1;
                    byte_count      <= '0;
                    state           <= FULL;
                end else begin
                    byte_count <= slot + 1'b1;
                    state      <= RECV;
                end
            end
        end
    end

    assign bus.data_out        = data_out;
    assign bus.frame_valid     = frame_valid;
    assign bus.frame_parity_ok = frame_parity_ok;
    assign bus.overrun         = overrun;
    assign bus.timeout         = timeout;
    assign bus.byte_count      = byte_count;
    assign bus.db_estado       = state;
endmodule

// File: tb/tb_receptor_multibyte.sv
// Bench for receptor_multibyte: one MSB-first and one LSB-first instance fed
// the same byte stream; expected frames queued per instance as the final
// byte is driven and compared when the frame appears.
module tb_receptor_multibyte;
    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       byte_valid = 1'b0;
    logic [7:0] byte_data = 8'h00;
    logic       byte_parity_ok = 1'b0;
    logic       frame_ack = 1'b0;

    always #5 clock = ~clock;

    receptor_multibyte_if #(.N_BYTES(2), .BYTE_W(8)) bus_m ();
    receptor_multibyte_if #(.N_BYTES(2), .BYTE_W(8)) bus_l ();

    assign bus_m.byte_valid     = byte_valid;
    assign bus_m.byte_data      = byte_data;
    assign bus_m.byte_parity_ok = byte_parity_ok;
    assign bus_m.frame_ack      = frame_ack;
    assign bus_l.byte_valid     = byte_valid;
    assign bus_l.byte_data      = byte_data;
    assign bus_l.byte_parity_ok = byte_parity_ok;
    assign bus_l.frame_ack      = frame_ack;

    receptor_multibyte #(.N_BYTES(2), .BYTE_W(8), .MSB_FIRST(1), .TIMEOUT_CYCLES(100))
        dut_m (.clock(clock), .reset(reset), .bus(bus_m));
    receptor_multibyte #(.N_BYTES(2), .BYTE_W(8), .MSB_FIRST(0), .TIMEOUT_CYCLES(100))
        dut_l (.clock(clock), .reset(reset), .bus(bus_l));

    typedef struct {
        logic [15:0] data;
        logic        par;
    } frame_t;

    frame_t q_m[$];
    frame_t q_l[$];
    int vectors     = 0;
    int miscompares = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic send(input logic [7:0] b, input logic p, input logic a);
        byte_data      = b;
        byte_parity_ok = p;
        frame_ack      = a;
        byte_valid     = 1'b1;
        tick();
        byte_valid     = 1'b0;
        frame_ack      = 1'b0;
    endtask

    task automatic ack_only();
        frame_ack = 1'b1;
        tick();
        frame_ack = 1'b0;
    endtask

    // Queue the frame that bytes b0 then b1 must produce in each instance.
    task automatic expect_frame(input logic [7:0] b0, input logic [7:0] b1, input logic par);
        frame_t f;
        f.data = {b0, b1};
        f.par  = par;
        q_m.push_back(f);
        f.data = {b1, b0};
        q_l.push_back(f);
    endtask

    task automatic check_frame(input string tag);
        frame_t em;
        frame_t el;
        check({tag, "_valid_m"}, 32'(bus_m.frame_valid), 32'd1);
        check({tag, "_valid_l"}, 32'(bus_l.frame_valid), 32'd1);
        if (q_m.size() == 0 || q_l.size() == 0) begin
            vectors++;
            miscompares++;
            $error("FAIL %s_queue observed=empty expected=entry", tag);
        end else begin
            em = q_m.pop_front();
            el = q_l.pop_front();
            check({tag, "_data_m"}, 32'(bus_m.data_out), 32'(em.data));
            check({tag, "_par_m"},  32'(bus_m.frame_parity_ok), 32'(em.par));
            check({tag, "_data_l"}, 32'(bus_l.data_out), 32'(el.data));
            check({tag, "_par_l"},  32'(bus_l.frame_parity_ok), 32'(el.par));
        end
    endtask

    task automatic check_cleared(input string tag);
        check({tag, "_data_m"},  32'(bus_m.data_out), 32'd0);
        check({tag, "_data_l"},  32'(bus_l.data_out), 32'd0);
        check({tag, "_valid"},   32'(bus_m.frame_valid), 32'd0);
        check({tag, "_par"},     32'(bus_m.frame_parity_ok), 32'd0);
        check({tag, "_ovr"},     32'(bus_m.overrun), 32'd0);
        check({tag, "_tmo"},     32'(bus_m.timeout), 32'd0);
        check({tag, "_cnt"},     32'(bus_m.byte_count), 32'd0);
        check({tag, "_state"},   32'(bus_m.db_estado), 32'd0);
    endtask

    initial begin
        // Reset state
        tick();
        tick();
        check_cleared("rst");
        reset = 1'b1;
        tick();

        // Frame 1: A5, 3C, parity ok
        send(8'hA5, 1'b1, 1'b0);
        check("f1_cnt", 32'(bus_m.byte_count), 32'd1);
        check("f1_state_recv", 32'(bus_m.db_estado), 32'd1);
        check("f1_not_valid", 32'(bus_m.frame_valid), 32'd0);
        expect_frame(8'hA5, 8'h3C, 1'b1);
        send(8'h3C, 1'b1, 1'b0);
        check_frame("f1");
        check("f1_state_full", 32'(bus_m.db_estado), 32'd2);
        check("f1_cnt_wrap", 32'(bus_m.byte_count), 32'd0);

        // Byte while FULL without ack is dropped
        send(8'h11, 1'b1, 1'b0);
        check("ovr_pulse_m", 32'(bus_m.overrun), 32'd1);
        check("ovr_pulse_l", 32'(bus_l.overrun), 32'd1);
        check("ovr_hold_data", 32'(bus_m.data_out), 32'hA53C);
        check("ovr_hold_valid", 32'(bus_m.frame_valid), 32'd1);
        tick();
        check("ovr_one_cycle", 32'(bus_m.overrun), 32'd0);
        check("full_held", 32'(bus_m.frame_valid), 32'd1);

        // Ack and new byte on the same cycle
        send(8'h22, 1'b1, 1'b1);
        check("ackb_state", 32'(bus_m.db_estado), 32'd1);
        check("ackb_cnt", 32'(bus_m.byte_count), 32'd1);
        check("ackb_no_ovr", 32'(bus_m.overrun), 32'd0);
        check("ackb_valid", 32'(bus_m.frame_valid), 32'd0);
        check("ackb_data_held", 32'(bus_m.data_out), 32'hA53C);
        expect_frame(8'h22, 8'h44, 1'b0);
        send(8'h44, 1'b0, 1'b0);
        check_frame("f2");

        // Ack alone releases the frame
        ack_only();
        check("ack_valid", 32'(bus_m.frame_valid), 32'd0);
        check("ack_state", 32'(bus_m.db_estado), 32'd0);
        check("ack_data_held", 32'(bus_m.data_out), 32'h2244);

        // Frame 3: ack in RECV ignored, second byte parity bad
        send(8'hA5, 1'b1, 1'b0);
        ack_only();
        check("recv_ack_state", 32'(bus_m.db_estado), 32'd1);
        check("recv_ack_cnt", 32'(bus_m.byte_count), 32'd1);
        expect_frame(8'hA5, 8'h3C, 1'b0);
        send(8'h3C, 1'b0, 1'b0);
        check_frame("f3");
        ack_only();

        // Asynchronous reset after one of two bytes
        send(8'h55, 1'b1, 1'b0);
        #3 reset = 1'b0;
        #1;
        check_cleared("rst_mid");
        tick();
        reset = 1'b1;
        tick();
        expect_frame(8'h01, 8'h02, 1'b1);
        send(8'h01, 1'b1, 1'b0);
        send(8'h02, 1'b1, 1'b0);
        check_frame("f4");
        ack_only();

`ifdef RECEPTOR_MULTIBYTE_TIMEOUT_EN
        // 100 idle clocks after a byte discard the partial frame
        send(8'h66, 1'b1, 1'b0);
        repeat (99) tick();
        check("tmo_not_yet", 32'(bus_m.timeout), 32'd0);
        check("tmo_still_recv", 32'(bus_m.db_estado), 32'd1);
        tick();
        check("tmo_pulse", 32'(bus_m.timeout), 32'd1);
        check("tmo_state", 32'(bus_m.db_estado), 32'd0);
        check("tmo_cnt", 32'(bus_m.byte_count), 32'd0);
        check("tmo_data_held", 32'(bus_m.data_out), 32'h0102);
        tick();
        check("tmo_one_cycle", 32'(bus_m.timeout), 32'd0);

        // Byte on the 100th idle clock still counts
        send(8'h77, 1'b1, 1'b0);
        repeat (99) tick();
        expect_frame(8'h77, 8'h88, 1'b1);
        send(8'h88, 1'b1, 1'b0);
        check("tmo_edge_none", 32'(bus_m.timeout), 32'd0);
        check_frame("f5");
        ack_only();
`else
        // Without the timeout feature RECV waits indefinitely
        send(8'h66, 1'b1, 1'b0);
        repeat (150) tick();
        check("wait_state", 32'(bus_m.db_estado), 32'd1);
        check("wait_tmo", 32'(bus_m.timeout), 32'd0);
        check("wait_cnt", 32'(bus_m.byte_count), 32'd1);
        expect_frame(8'h66, 8'h88, 1'b1);
        send(8'h88, 1'b1, 1'b0);
        check_frame("f5");
        ack_only();
`endif

        // Reset while a frame is held
        expect_frame(8'h99, 8'hAA, 1'b1);
        send(8'h99, 1'b1, 1'b0);
        send(8'hAA, 1'b1, 1'b0);
        check_frame("f6");
        #2 reset = 1'b0;
        #1;
        check_cleared("rst_full");
        tick();
        reset = 1'b1;
        tick();
        expect_frame(8'h5A, 8'hC3, 1'b1);
        send(8'h5A, 1'b1, 1'b0);
        send(8'hC3, 1'b1, 1'b0);
        check_frame("f7");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
